// File: rtl/mem_load_tracker.sv
// Tracks loads outstanding at memory by response tag and matches returning data
// back to the owning LSQ entry; flushed loads still free their tag but deliver nothing.
module mem_load_tracker #(
    parameter int NUM_MEM_TAGS = 15,
    parameter int MEM_TAG_W    = 4,
    parameter int LSQ_TAG_W    = 5,
    parameter int DATA_W       = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [LSQ_TAG_W-1:0] issue_lsq_tag,
    input  logic [MEM_TAG_W-1:0] mem_response,
    input  logic [MEM_TAG_W-1:0] mem_tag,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic                 flush,
    output logic                 issue_retry,
    output logic                 ld_valid,
    output logic [LSQ_TAG_W-1:0] ld_tag,
    output logic [DATA_W-1:0]    ld_value,
    output logic [MEM_TAG_W:0]   outstanding,
    output logic                 full,
    output logic                 err
);

    localparam int                 DEPTH    = 2 ** MEM_TAG_W;
    localparam logic [MEM_TAG_W:0] FULL_CNT = (MEM_TAG_W + 1)'(NUM_MEM_TAGS);
    localparam logic [MEM_TAG_W:0] ONE_CNT  = (MEM_TAG_W + 1)'(1);

    logic [DEPTH-1:0]     pending_r;
    logic [DEPTH-1:0]     live_r;
    logic [LSQ_TAG_W-1:0] lsq_tag_r [DEPTH];
    logic [MEM_TAG_W:0]   outstanding_r;
    logic                 ld_valid_r;
    logic [LSQ_TAG_W-1:0] ld_tag_r;
    logic [DATA_W-1:0]    ld_value_r;
    logic                 err_r;

    logic issue_ok_s;
    logic issue_bad_s;
    logic ret_seen_s;
    logic ret_hit_s;
    logic recycle_s;
    logic issue_clash_s;
    logic deliver_s;
    logic inc_s;
    logic dec_s;
    logic protocol_err_s;

    function automatic logic tag_in_range(input logic [MEM_TAG_W-1:0] tag);
        return (tag != '0) && ({1'b0, tag} <= FULL_CNT);
    endfunction

    // Classify this cycle's issue and return against the current table state.
    always_comb begin
        issue_ok_s     = issue_valid && tag_in_range(mem_response);
        issue_bad_s    = issue_valid && (mem_response != '0) && !tag_in_range(mem_response);
        ret_seen_s     = (mem_tag != '0);
        ret_hit_s      = ret_seen_s && pending_r[mem_tag];
        recycle_s      = issue_ok_s && ret_hit_s && (mem_tag == mem_response);
        // An issue onto a busy tag is only legal when that tag frees in the same cycle.
        issue_clash_s  = issue_ok_s && pending_r[mem_response] && !recycle_s;
        deliver_s      = ret_hit_s && live_r[mem_tag];
        inc_s          = issue_ok_s && !issue_clash_s;
        dec_s          = ret_hit_s;
        protocol_err_s = (ret_seen_s && !ret_hit_s) || issue_clash_s || issue_bad_s;
    end

    // Entry table: flush kills liveness, return frees, issue (last, so it wins) allocates.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pending_r <= '0;
            live_r    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                lsq_tag_r[i] <= '0;
            end
        end else begin
            if (flush) begin
                live_r <= '0;
            end
            if (ret_hit_s) begin
                pending_r[mem_tag] <= 1'b0;
                live_r[mem_tag]    <= 1'b0;
            end
            if (issue_ok_s) begin
                pending_r[mem_response] <= 1'b1;
                live_r[mem_response]    <= !flush;
                lsq_tag_r[mem_response] <= issue_lsq_tag;
            end
        end
    end

    // Occupancy counter; saturates instead of wrapping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            outstanding_r <= '0;
        end else begin
            case ({inc_s, dec_s})
                2'b10: begin
                    if (outstanding_r != FULL_CNT) begin
                        outstanding_r <= outstanding_r + ONE_CNT;
                    end
                end
                2'b01: begin
                    if (outstanding_r != '0) begin
                        outstanding_r <= outstanding_r - ONE_CNT;
                    end
                end
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Load delivery register; tag and value hold when nothing is delivered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ld_valid_r <= 1'b0;
            ld_tag_r   <= '0;
            ld_value_r <= '0;
        end else begin
            ld_valid_r <= deliver_s;
            if (deliver_s) begin
                ld_tag_r   <= lsq_tag_r[mem_tag];
                ld_value_r <= mem_data;
            end
        end
    end

    // Sticky protocol error.
    always_ff @(posedge clock) begin
        if (!reset) begin
            err_r <= 1'b0;
        end else if (protocol_err_s) begin
            err_r <= 1'b1;
        end
    end

    assign issue_retry = issue_valid && (mem_response == '0);
    assign full        = (outstanding_r == FULL_CNT);
    assign outstanding = outstanding_r;
    assign ld_valid    = ld_valid_r;
    assign ld_tag      = ld_tag_r;
    assign ld_value    = ld_value_r;
    assign err         = err_r;

endmodule

// File: tb/tb_mem_load_tracker.sv
// Randomized bench for mem_load_tracker against a tag-table reference model.
module tb_mem_load_tracker;

    localparam int NT = 15;
    localparam int MW = 4;
    localparam int LW = 5;
    localparam int DW = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          issue_valid;
    logic [LW-1:0] issue_lsq_tag;
    logic [MW-1:0] mem_response;
    logic [MW-1:0] mem_tag;
    logic [DW-1:0] mem_data;
    logic          flush;
    logic          issue_retry;
    logic          ld_valid;
    logic [LW-1:0] ld_tag;
    logic [DW-1:0] ld_value;
    logic [MW:0]   outstanding;
    logic          full;
    logic          err;

    mem_load_tracker #(.NUM_MEM_TAGS(NT), .MEM_TAG_W(MW), .LSQ_TAG_W(LW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_lsq_tag(issue_lsq_tag),
        .mem_response(mem_response), .mem_tag(mem_tag), .mem_data(mem_data), .flush(flush),
        .issue_retry(issue_retry), .ld_valid(ld_valid), .ld_tag(ld_tag), .ld_value(ld_value),
        .outstanding(outstanding), .full(full), .err(err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one record per memory tag plus the visible output state.
    bit            m_pend [16];
    bit            m_live [16];
    logic [LW-1:0] m_lsq  [16];
    bit            m_ld_valid;
    logic [LW-1:0] m_ld_tag;
    logic [DW-1:0] m_ld_value;
    bit            m_err;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 1; i <= NT; i++) if (m_pend[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_pend[i] = 1'b0;
            m_live[i] = 1'b0;
            m_lsq[i]  = '0;
        end
        m_ld_valid = 1'b0;
        m_ld_tag   = '0;
        m_ld_value = '0;
        m_err      = 1'b0;
    endtask

    task automatic check_regs();
        check_eq("ld_valid", ld_valid, m_ld_valid);
        check_eq("ld_tag", ld_tag, m_ld_tag);
        check_eq("ld_value", ld_value, m_ld_value);
        check_eq("outstanding", outstanding, m_count());
        check_eq("err", err, m_err);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; issue_valid = 1'b0; issue_lsq_tag = '0; mem_response = '0;
        mem_tag = '0; mem_data = '0; flush = 1'b0;
        model_reset();
        @(posedge clock); #1;
        check_regs();
        check_eq("reset_full", full, 1'b0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic step(input bit iv, input int ilsq, input int resp, input int mt,
                        input logic [DW-1:0] md, input bit fl);
        bit hit;
        bit recycle;
        bit clash;
        @(negedge clock);
        issue_valid = iv; issue_lsq_tag = LW'(ilsq); mem_response = MW'(resp);
        mem_tag = MW'(mt); mem_data = md; flush = fl;
        #1;
        check_eq("issue_retry", issue_retry, iv && (resp == 0));
        check_eq("full", full, m_count() == NT);
        hit     = (mt != 0) && m_pend[mt];
        recycle = hit && iv && (mt == resp);
        clash   = iv && (resp != 0) && m_pend[resp] && !recycle;
        m_ld_valid = 1'b0;
        if (mt != 0) begin
            if (hit) begin
                if (m_live[mt]) begin
                    m_ld_valid = 1'b1;
                    m_ld_tag   = m_lsq[mt];
                    m_ld_value = md;
                end
                m_pend[mt] = 1'b0;
                m_live[mt] = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        if (fl) for (int i = 0; i < 16; i++) m_live[i] = 1'b0;
        if (iv && resp != 0) begin
            if (clash) m_err = 1'b1;
            m_pend[resp] = 1'b1;
            m_live[resp] = !fl;
            m_lsq[resp]  = LW'(ilsq);
        end
        @(posedge clock); #1;
        check_regs();
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 0, '0, 1'b0);
    endtask

    initial begin
        int pend_list[$];
        int free_list[$];
        int r;
        int resp;
        int mt;
        bit iv;
        reset = 1'b1; issue_valid = 1'b0; issue_lsq_tag = '0; mem_response = '0;
        mem_tag = '0; mem_data = '0; flush = 1'b0;
        model_reset();
        do_reset();

        // Basic issue / return with one-cycle delivery
        step(1'b1, 3, 2, 0, '0, 1'b0);
        check_eq("t1_out1", outstanding, 1);
        idle();
        step(1'b0, 0, 0, 2, 64'hDEAD, 1'b0);
        check_eq("t1_ld_tag", ld_tag, 5'h03);
        check_eq("t1_ld_value", ld_value, 64'hDEAD);
        check_eq("t1_out0", outstanding, 0);

        // Rejected issue
        step(1'b1, 4, 0, 0, '0, 1'b0);
        check_eq("t2_out", outstanding, 0);

        // Fill all tags, then free one
        for (int t = 1; t <= NT; t++) step(1'b1, t, t, 0, '0, 1'b0);
        check_eq("t3_full", full, 1'b1);
        check_eq("t3_out", outstanding, NT);
        step(1'b0, 0, 0, 7, 64'h77, 1'b0);
        check_eq("t3_not_full", full, 1'b0);
        for (int t = 1; t <= NT; t++) if (t != 7) step(1'b0, 0, 0, t, 64'(t * 3), 1'b0);

        // Flushed load frees its tag silently
        step(1'b1, 10, 3, 0, '0, 1'b0);
        step(1'b0, 0, 0, 0, '0, 1'b1);
        step(1'b0, 0, 0, 3, 64'hBEEF, 1'b0);
        check_eq("t4_ld_valid", ld_valid, 1'b0);
        check_eq("t4_err", err, 1'b0);

        // Tag recycled on its return cycle
        step(1'b1, 1, 4, 0, '0, 1'b0);
        step(1'b1, 2, 4, 4, 64'h1111, 1'b0);
        check_eq("t5_first", ld_tag, 5'h01);
        step(1'b0, 0, 0, 4, 64'h2222, 1'b0);
        check_eq("t5_second", ld_tag, 5'h02);

        // Stray return, then reset clears the sticky error
        step(1'b0, 0, 0, 9, 64'h9, 1'b0);
        check_eq("t6_err", err, 1'b1);
        idle();
        do_reset();

        // Randomized traffic, mostly legal with occasional violations
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            pend_list.delete();
            free_list.delete();
            for (int i = 1; i <= NT; i++) begin
                if (m_pend[i]) pend_list.push_back(i);
                else free_list.push_back(i);
            end
            iv = ($urandom_range(0, 1) == 1);
            r  = $urandom_range(0, 99);
            if (r < 10) resp = 0;
            else if (r < 13) resp = $urandom_range(1, NT);
            else if (free_list.size() != 0) resp = free_list[$urandom_range(0, free_list.size() - 1)];
            else resp = 0;
            r = $urandom_range(0, 99);
            if (r < 50 && pend_list.size() != 0) mt = pend_list[$urandom_range(0, pend_list.size() - 1)];
            else if (r >= 50 && r < 52) mt = $urandom_range(1, NT);
            else mt = 0;
            step(iv, $urandom_range(0, 31), resp, mt, {$urandom, $urandom}, $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
